// File: rtl/dram_port_arbiter.sv
// Two-master round-robin arbiter for a single DRAM data port.
// Each access runs IDLE -> ACCESS -> (WAIT x RD_LAT) -> RESP with registered outputs.
module dram_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ready,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          grant,
  output logic          busy
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic          we_q, we_d;
  logic          grant_q, grant_d;
  logic          last_grant_q, last_grant_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic          m0_ready_q, m0_ready_d;
  logic          m1_ready_q, m1_ready_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel;
  logic          capture;

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    we_d         = we_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    cnt_d        = cnt_q;
    capture      = 1'b0;
    // m1 wins when it alone requests, or on a tie when m0 was served last
    sel          = m1_req & (~m0_req | ~last_grant_q);

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant_d     = sel;
          mem_addr_d  = sel ? m1_addr  : m0_addr;
          mem_wdata_d = sel ? m1_wdata : m0_wdata;
          we_d        = sel ? m1_we    : m0_we;
          mem_we_d    = sel ? m1_we    : m0_we;
          cnt_d       = '0;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = RESP;
        end else if (RD_LAT == 0) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      if (grant_q) m1_rdata_d = mem_rdata;
      else         m0_rdata_d = mem_rdata;
    end

    // RESP is entered only from ACCESS/WAIT, so the pulse lasts exactly one cycle
    m0_ready_d = (state_d == RESP) && !grant_q;
    m1_ready_d = (state_d == RESP) &&  grant_q;
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      we_q         <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      m0_ready_q   <= 1'b0;
      m1_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      we_q         <= we_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      m0_ready_q   <= m0_ready_d;
      m1_ready_q   <= m1_ready_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign m0_ready  = m0_ready_q;
  assign m1_ready  = m1_ready_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Random-stimulus bench for dram_port_arbiter at RD_LAT = 0, 1 and 3, each instance
// compared every cycle against a transaction-level schedule model.
module tb_dram_port_arbiter;

  localparam int NCYC = 2500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [2:0] done = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_lat
    localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 1 : 3);

    logic        rst;
    logic        req[2];
    logic        we[2];
    logic [31:0] addr[2];
    logic [31:0] wdata[2];
    logic [31:0] rdata[2];
    logic        rdy[2];
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, grant, busy;

    dram_port_arbiter #(.AW(32), .DW(32), .RD_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
      .m0_rdata(rdata[0]), .m0_ready(rdy[0]),
      .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
      .m1_rdata(rdata[1]), .m1_ready(rdy[1]),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
    );

    // Model: one active transaction (granted at t0, completing at r0) plus the
    // values each output should hold between transactions.
    bit          act, a_we;
    int          a_m, t0, r0, idle_at, lastg, e_grant;
    logic [31:0] e_addr, e_wdata;
    logic [31:0] e_rdata[2];
    bit          pend[2];
    logic [31:0] dr[256];

    task automatic mdl_reset(input int c);
      act     = 0;
      idle_at = c + 1;
      lastg   = 1;
      e_grant = 0;
      e_addr  = '0;
      e_wdata = '0;
      for (int m = 0; m < 2; m++) begin
        e_rdata[m] = '0;
        pend[m]    = 0;
        req[m]     = 1'b0;
      end
    endtask

    initial begin
      string p;
      bit    rst_now;
      p = $sformatf("lat%0d", LAT);
      rst = 1'b1;
      mem_rdata = '0;
      for (int m = 0; m < 2; m++) begin
        we[m] = 1'b0; addr[m] = '0; wdata[m] = '0;
      end
      mdl_reset(-1);
      t0 = -10; r0 = -10;
      for (int c = 0; c < NCYC; c++) begin
        @(posedge clk); #1;
        if (act && c == r0 && !a_we) e_rdata[a_m] = dr[(c - 1) & 255];

        check_eq({p, ".busy"},    64'(busy),      64'(act && c > t0 && c <= r0));
        check_eq({p, ".mem_we"},  64'(mem_we),    64'(act && c == t0 + 1 && a_we));
        check_eq({p, ".mem_addr"}, 64'(mem_addr), 64'(e_addr));
        check_eq({p, ".mem_wdata"}, 64'(mem_wdata), 64'(e_wdata));
        check_eq({p, ".grant"},   64'(grant),     64'(e_grant));
        for (int m = 0; m < 2; m++) begin
          check_eq($sformatf("%s.m%0d_ready", p, m), 64'(rdy[m]), 64'(act && c == r0 && a_m == m));
          check_eq($sformatf("%s.m%0d_rdata", p, m), 64'(rdata[m]), 64'(e_rdata[m]));
        end

        if (act && c == r0) begin
          lastg     = a_m;
          pend[a_m] = 0;
          act       = 0;
        end

        // Drive this cycle's inputs
        dr[c & 255] = $urandom;
        mem_rdata   = dr[c & 255];
        rst_now = (c < 3) || ($urandom_range(0, 99) == 0) ||
                  (act && c == t0 + 1 && a_we && $urandom_range(0, 3) == 0);
        rst = rst_now;
        for (int m = 0; m < 2; m++) begin
          if (!pend[m]) begin
            if ($urandom_range(0, 3) != 0) begin
              req[m]   = 1'b1;
              we[m]    = $urandom_range(0, 1) == 1;
              addr[m]  = $urandom;
              wdata[m] = $urandom;
              pend[m]  = 1;
            end else begin
              req[m]  = 1'b0;
              addr[m] = $urandom;
            end
          end
        end

        if (rst_now) begin
          mdl_reset(c);
        end else if (!act && c >= idle_at && (req[0] || req[1])) begin
          if (req[0] && req[1]) a_m = 1 - lastg;
          else                  a_m = req[1] ? 1 : 0;
          act     = 1;
          t0      = c;
          a_we    = we[a_m];
          e_addr  = addr[a_m];
          e_wdata = wdata[a_m];
          e_grant = a_m;
          r0      = c + 2 + (a_we ? 0 : LAT);
          idle_at = r0 + 1;
        end
      end
      done[g] = 1'b1;
    end
  end

  initial begin
    repeat (NCYC + 20) @(posedge clk);
    #2;
    check_eq("all_done", 64'(done), 64'(3'b111));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
